// File: rtl/real_clock_v7_pkg.sv
// Shared constants and BCD helpers for the six-digit real-time clock.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package real_clock_v7_pkg;

  localparam int BCD_W       = 4;
  localparam int MAX_HOURS   = 23;
  localparam int MAX_MIN_SEC = 59;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd_pair_t;

  function automatic bcd_pair_t to_bcd(input logic [6:0] value);
    bcd_pair_t r;
    r.tens  = 4'(value / 7'd10);
    r.units = 4'(value % 7'd10);
    return r;
  endfunction

  function automatic logic [6:0] from_bcd(input bcd_pair_t p);
    return 7'(p.tens) * 7'd10 + 7'(p.units);
  endfunction

  // Advance a BCD pair by one; wrap forces the rollover to 00.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t p, input logic wrap);
    bcd_pair_t r;
    r = p;
    if (wrap) begin
      r = '0;
    end else if (p.units == 4'd9) begin
      r.tens  = p.tens + 4'd1;
      r.units = '0;
    end else begin
      r.units = p.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/real_clock_v7_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder with selectable polarity.
// Non-BCD codes blank the digit.
module bcd_to_seg7
  import real_clock_v7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/real_clock_v7.sv
// Six-digit BCD real-time clock: prescaled 1 Hz tick, run/hold, time load,
// 12/24-hour display, minute alarm and registered 7-segment outputs.
module real_clock_v7
  import real_clock_v7_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int TICK_DIV       = CLK_FREQ_HZ,
  parameter bit HOUR_MODE_12   = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  output logic [6:0] left_seconds_out,
  output logic [6:0] right_seconds_out,
  output logic [6:0] left_minutes_out,
  output logic [6:0] right_minutes_out,
  output logic [6:0] left_hours_out,
  output logic [6:0] right_hours_out,
  output logic       pm_out,
  output logic       tick_1hz,
  output logic       alarm_out
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0] HR_MAX = 5'(MAX_HOURS);
  localparam logic [5:0] MS_MAX = 6'(MAX_MIN_SEC);

  localparam logic [6:0] RST_ZERO = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
  localparam logic [6:0] RST_ONE  = SEG_ACTIVE_LOW ? ~SEG_1 : SEG_1;
  localparam logic [6:0] RST_TWO  = SEG_ACTIVE_LOW ? ~SEG_2 : SEG_2;
  localparam logic [6:0] RST_HR_L = HOUR_MODE_12 ? RST_ONE : RST_ZERO;
  localparam logic [6:0] RST_HR_R = HOUR_MODE_12 ? RST_TWO : RST_ZERO;

  logic [PRE_W-1:0] prescaler;
  bcd_pair_t        sec_q, min_q, hr_q;
  bcd_pair_t        ld_sec, ld_min, ld_hr;
  bcd_pair_t        disp_hr;
  logic [6:0]       hr_bin, min_bin, h12;
  logic             tick_edge, sec_wrap, min_wrap, hr_wrap;
  logic             pm_next, alarm_hit;
  logic [6:0]       seg_ls, seg_rs, seg_lm, seg_rm, seg_lh, seg_rh;

  assign tick_edge = run_en && !set_en && (prescaler == PRE_LAST);
  assign sec_wrap  = (sec_q == 8'h59);
  assign min_wrap  = (min_q == 8'h59);
  assign hr_wrap   = (hr_q  == 8'h23);

  // Out-of-range load fields collapse to zero independently.
  assign ld_hr  = to_bcd((set_hours   > HR_MAX) ? 7'd0 : 7'(set_hours));
  assign ld_min = to_bcd((set_minutes > MS_MAX) ? 7'd0 : 7'(set_minutes));
  assign ld_sec = to_bcd((set_seconds > MS_MAX) ? 7'd0 : 7'(set_seconds));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      tick_1hz  <= 1'b0;
    end else if (set_en) begin
      prescaler <= '0;
      sec_q     <= ld_sec;
      min_q     <= ld_min;
      hr_q      <= ld_hr;
      tick_1hz  <= 1'b0;
    end else begin
      tick_1hz <= tick_edge;
      if (run_en) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
      end
      if (tick_edge) begin
        sec_q <= bcd_inc(sec_q, sec_wrap);
        if (sec_wrap) begin
          min_q <= bcd_inc(min_q, min_wrap);
          if (min_wrap) begin
            hr_q <= bcd_inc(hr_q, hr_wrap);
          end
        end
      end
    end
  end

  assign hr_bin  = from_bcd(hr_q);
  assign min_bin = from_bcd(min_q);

  // Internal hours stay 24 h; only the displayed value is folded to 12 h.
  always_comb begin
    h12     = hr_bin;
    pm_next = 1'b0;
    disp_hr = hr_q;
    if (HOUR_MODE_12) begin
      pm_next = (hr_bin >= 7'd12);
      if (hr_bin == 7'd0) begin
        h12 = 7'd12;
      end else if (hr_bin > 7'd12) begin
        h12 = hr_bin - 7'd12;
      end
      disp_hr = to_bcd(h12);
    end
  end

  assign alarm_hit = alarm_en && (alarm_hours <= HR_MAX) && (alarm_minutes <= MS_MAX) &&
                     (hr_bin == 7'(alarm_hours)) && (min_bin == 7'(alarm_minutes));

  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_ls (.digit(sec_q.tens),    .seg(seg_ls));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_rs (.digit(sec_q.units),   .seg(seg_rs));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lm (.digit(min_q.tens),    .seg(seg_lm));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_rm (.digit(min_q.units),   .seg(seg_rm));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lh (.digit(disp_hr.tens),  .seg(seg_lh));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_rh (.digit(disp_hr.units), .seg(seg_rh));

  // The alarm latches only on the :00 second, so re-enabling mid-minute stays quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_seconds_out  <= RST_ZERO;
      right_seconds_out <= RST_ZERO;
      left_minutes_out  <= RST_ZERO;
      right_minutes_out <= RST_ZERO;
      left_hours_out    <= RST_HR_L;
      right_hours_out   <= RST_HR_R;
      pm_out            <= 1'b0;
      alarm_out         <= 1'b0;
    end else begin
      left_seconds_out  <= seg_ls;
      right_seconds_out <= seg_rs;
      left_minutes_out  <= seg_lm;
      right_minutes_out <= seg_rm;
      left_hours_out    <= seg_lh;
      right_hours_out   <= seg_rh;
      pm_out            <= pm_next;
      alarm_out         <= alarm_hit && ((sec_q == 8'h00) || alarm_out);
    end
  end

endmodule
